// File: rtl/rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
// Module   : rs_syndrome_calc
// Brief    : GF(2^8) Reed-Solomon syndrome calculator (Horner, alpha^1..NSYM)
// Revision : 1.0 - initial release
// ============================================================================
module rs_syndrome_calc #(
    parameter int N    = 255,
    parameter int NSYM = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        din,
    input  logic              din_valid,
    input  logic              din_sop,
    output logic [8*NSYM-1:0] synd,
    output logic              synd_valid,
    output logic              err_flag,
    output logic              busy
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_RUN      = 1'b1;
    localparam logic [7:0] c_LAST_CNT = 8'(N - 1);

    // Constant multiply by alpha^k over 0x11D; unrolls to a pure XOR network.
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] a, input int k);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < k; i++) begin
            r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        r_acc [NSYM];
    logic [8*NSYM-1:0] w_horner;
    logic              w_start;
    logic              w_step;
    logic              w_done;

    generate
        for (genvar k = 0; k < NSYM; k++) begin : g_horner
            assign w_horner[8*k +: 8] = mul_alpha_pow(r_acc[k], k + 1) ^ din;
        end
    endgenerate

    // A new sop always wins, even mid-codeword, which silently drops the partial.
    assign w_start = din_valid & din_sop;
    assign w_step  = din_valid & ~din_sop & (r_state == c_RUN);
    assign w_done  = w_step & (r_cnt == c_LAST_CNT);

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_RUN;
        end else if (w_done) begin
            w_state_nxt = c_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= 8'd0;
            synd       <= '0;
            err_flag   <= 1'b0;
            synd_valid <= 1'b0;
            for (int k = 0; k < NSYM; k++) begin
                r_acc[k] <= 8'd0;
            end
        end else begin
            r_state    <= w_state_nxt;
            synd_valid <= w_done;
            if (w_start) begin
                r_cnt <= 8'd1;
                for (int k = 0; k < NSYM; k++) begin
                    r_acc[k] <= din;
                end
            end else if (w_done) begin
                r_cnt    <= 8'd0;
                synd     <= w_horner;
                err_flag <= |w_horner;
            end else if (w_step) begin
                r_cnt <= r_cnt + 8'd1;
                for (int k = 0; k < NSYM; k++) begin
                    r_acc[k] <= w_horner[8*k +: 8];
                end
            end
        end
    end

    assign busy = (r_state == c_RUN);

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_syndrome_calc
// Brief    : Directed bench for rs_syndrome_calc with a direct-evaluation model
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_syndrome_calc;

    localparam int N    = 255;
    localparam int NSYM = 16;
    localparam int W    = 8 * NSYM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    din = 8'd0;
    logic          din_valid = 1'b0;
    logic          din_sop = 1'b0;
    logic [W-1:0]  synd;
    logic          synd_valid;
    logic          err_flag;
    logic          busy;

    rs_syndrome_calc #(.N(N), .NSYM(NSYM)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
        .synd       (synd),
        .synd_valid (synd_valid),
        .err_flag   (err_flag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    logic en = 1'b0;

    // Model state describing what the DUT must show after the next rising edge.
    logic         m_inrun = 1'b0;
    logic         m_pulse = 1'b0;
    logic [W-1:0] m_hold  = '0;
    logic         m_herr  = 1'b0;
    logic [7:0]   m_sym [$];

    logic [7:0] gexp [255];
    logic [7:0] cw   [N];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = xtime(a);
        end
        return r;
    endfunction

    // S_k = sum_i c_i * alpha^(k*deg_i), evaluated term by term.
    function automatic logic [W-1:0] eval_synd();
        logic [W-1:0] v = '0;
        for (int k = 1; k <= NSYM; k++) begin
            logic [7:0] s = 8'd0;
            for (int i = 0; i < N; i++) begin
                s = s ^ gf_mul(m_sym[i], gexp[(k * (N - 1 - i)) % 255]);
            end
            v[8*(k-1) +: 8] = s;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] d, input logic r);
        @(negedge clk);
        rst = r; din_valid = v; din_sop = s; din = d;
        m_pulse = 1'b0;
        if (!r) begin
            m_inrun = 1'b0; m_sym.delete(); m_hold = '0; m_herr = 1'b0;
        end else if (v && s) begin
            m_sym.delete(); m_sym.push_back(d); m_inrun = 1'b1;
        end else if (v && m_inrun) begin
            m_sym.push_back(d);
            if (m_sym.size() == N) begin
                m_hold  = eval_synd();
                m_herr  = |m_hold;
                m_pulse = 1'b1;
                m_inrun = 1'b0;
                m_sym.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom % 2), 8'($urandom), 1'b1);
    endtask

    task automatic send_cw(input int gap_pct);
        for (int i = 0; i < N; i++) begin
            while (int'($urandom % 100) < gap_pct) idle(1);
            step(1'b1, i == 0, cw[i], 1'b1);
        end
    endtask

    task automatic clear_cw();
        for (int i = 0; i < N; i++) cw[i] = 8'd0;
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (en) begin
                check("busy", W'(busy), W'(m_inrun));
                check("synd_valid", W'(synd_valid), W'(m_pulse));
                check("synd", synd, m_hold);
                check("err_flag", W'(err_flag), W'(m_herr));
                if (synd_valid) pulses++;
            end
        end
    end

    initial begin
        logic [7:0] e;
        logic [7:0] g [17];
        logic [7:0] c [N];
        int p0;

        e = 8'd1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = e;
            e = xtime(e);
        end

        // Reset
        step(1'b0, 1'b0, 8'd0, 1'b0);
        en = 1'b1;
        step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        idle(2);
        check("reset_synd", synd, '0);
        check("reset_busy", W'(busy), '0);

        // All-zero codeword
        clear_cw();
        send_cw(0);
        idle(1);
        check("zero_cw_synd", synd, '0);
        check("zero_cw_err", W'(err_flag), '0);

        // Degree-0 single symbol
        cw[N-1] = 8'h01;
        send_cw(0);
        idle(1);
        check("deg0_synd", synd, {NSYM{8'h01}});
        check("deg0_err", W'(err_flag), W'(1));

        // Degree-1 single symbol
        clear_cw();
        cw[N-2] = 8'h01;
        send_cw(0);
        idle(1);
        check("deg1_S1",  W'(synd[7:0]),     W'(8'h02));
        check("deg1_S2",  W'(synd[15:8]),    W'(8'h04));
        check("deg1_S8",  W'(synd[63:56]),   W'(8'h1D));
        check("deg1_S9",  W'(synd[71:64]),   W'(8'h3A));
        check("deg1_S12", W'(synd[95:88]),   W'(8'hCD));
        check("deg1_S16", W'(synd[127:120]), W'(8'h4C));

        // Encoder codeword: c(x) = m(x) * prod_{k=1..NSYM} (x + alpha^k)
        for (int j = 0; j < 17; j++) g[j] = 8'd0;
        g[0] = 8'h01;
        for (int k = 1; k <= NSYM; k++) begin
            for (int j = k; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], gexp[k]);
            g[0] = gf_mul(g[0], gexp[k]);
        end
        for (int i = 0; i < N; i++) c[i] = 8'd0;
        for (int j = 0; j < N - NSYM; j++) begin
            logic [7:0] mj = 8'($urandom);
            for (int t = 0; t <= NSYM; t++) c[j+t] = c[j+t] ^ gf_mul(mj, g[t]);
        end
        for (int i = 0; i < N; i++) cw[i] = c[N-1-i];
        send_cw(0);
        idle(1);
        check("enc_nogap_synd", synd, '0);
        check("enc_nogap_err", W'(err_flag), '0);
        send_cw(30);
        idle(1);
        check("enc_gap_synd", synd, '0);
        check("enc_gap_err", W'(err_flag), '0);
        cw[37] = cw[37] ^ 8'h5A;
        send_cw(30);
        idle(1);
        check("corrupt_err", W'(err_flag), W'(1));
        check("corrupt_nonzero", W'(synd != '0), W'(1));

        // Abort by sop at symbol 100
        p0 = pulses;
        for (int i = 0; i < 100; i++) step(1'b1, i == 0, 8'($urandom), 1'b1);
        clear_cw();
        send_cw(0);
        idle(1);
        check("abort_sop_pulses", W'(pulses - p0), W'(1));
        check("abort_sop_synd", synd, '0);

        // Reset at symbol 50, then a full codeword, then two back-to-back
        p0 = pulses;
        for (int i = 0; i < 50; i++) step(1'b1, i == 0, 8'($urandom), 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        clear_cw();
        cw[N-2] = 8'h01;
        send_cw(0);
        clear_cw();
        send_cw(0);
        cw[N-1] = 8'h01;
        send_cw(0);
        idle(2);
        check("rst_abort_pulses", W'(pulses - p0), W'(3));
        check("b2b_last_synd", synd, {NSYM{8'h01}});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Syndrome calculator for the receive side of the GF(2^8) Reed-Solomon link. It sits at the front of the RS decoder and consumes one received codeword symbol per accepted cycle. It evaluates the received polynomial at alpha^1..alpha^NSYM using Horner recurrences, then presents all syndromes plus an error flag one cycle after the last symbol. Its output feeds the key-equation solver; an all-zero result means the codeword is accepted unchanged.

## Interface
- N, 255: codeword length in symbols (data + parity); 2 <= N <= 255.
- NSYM, 16: number of parity symbols = number of syndromes; 1 <= NSYM <= 32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-low.
- din  input  8  received symbol; first symbol is the highest-degree coefficient (degree N-1).
- din_valid  input  1  din is valid this cycle; low cycles are gaps and change no state.
- din_sop  input  1  qualifies din_valid; marks the first symbol of a codeword.
- synd  output  8*NSYM  syndrome vector; S_k occupies bits [8k-1:8k-8], k = 1..NSYM.
- synd_valid  output  1  one-cycle pulse when synd/err_flag update.
- err_flag  output  1  OR of all syndromes being nonzero; updated with synd.
- busy  output  1  high while a codeword is partially received.

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02. Roots alpha^1..alpha^NSYM match the team's encoder generator polynomial.
- Each accumulator acc_k is 8 bits and uses a constant multiplier by alpha^k. Multipliers are pure XOR networks derived from 0x11D. Addition is XOR; there is no carry and no width growth.
- State: IDLE, RUN. cnt (8 bits) counts accepted symbols in the current codeword.
- IDLE:
  - din_valid & din_sop: acc_k <= din for all k; cnt <= 1; go to RUN. If N would be reached on this symbol, the RUN completion rule applies instead.
  - din_valid & !din_sop: symbol is ignored; no state change.
- RUN:
  - din_valid & !din_sop: acc_k <= acc_k*alpha^k ^ din; cnt <= cnt+1.
  - Completion: when the accepted symbol is number N (cnt == N-1 before the update), synd S_k <= acc_k*alpha^k ^ din. err_flag <= |(those values). synd_valid <= 1. Return to IDLE; cnt <= 0.
  - din_valid & din_sop mid-codeword: the partial codeword is discarded silently. Restart exactly as in IDLE: acc_k <= din, cnt <= 1. No synd_valid is produced.
  - !din_valid: hold all state. Gaps of any length are allowed.
- Back-to-back codewords: the sop of codeword i+1 is legal in the cycle immediately after the last symbol of codeword i. No bubble is required.
- synd and err_flag hold their values until the next completion.
- busy = (state == RUN).

## Timing
- Reset (rst low at a clock edge): state IDLE, cnt 0, all acc_k 0, synd 0, err_flag 0, synd_valid 0, busy 0.
- Reset asserted mid-codeword aborts the codeword; no synd_valid follows.
- Latency: synd_valid is high in the cycle after the edge that accepted symbol N. It lasts exactly one cycle.
- Throughput: one symbol per clock, sustained indefinitely.
- Each accumulator update is one constant multiply plus one XOR per cycle. There is no multi-cycle path.
- din_sop without din_valid has no effect.

## Test plan
- All-zero codeword of 255 symbols after reset -> one synd_valid pulse, synd all 0x00, err_flag 0. busy rises with the sop and falls after the last symbol.
- Symbol 0x01 at position N-1 only (degree 0), all others 0 -> every S_k = 0x01; err_flag 1.
- Symbol 0x01 at position N-2 only (degree 1) -> S_k = alpha^k: S_1=0x02, S_2=0x04, S_8=0x1D, S_9=0x3A, S_12=0xCD, S_16=0x4C.
- A valid codeword from the team's RS encoder, sent with random din_valid gaps, then the same codeword corrupted by XORing 0x5A into one symbol -> first result is all-zero with err_flag 0; second is nonzero with err_flag 1. Results must match the gap-free run bit-exactly.
- din_sop reasserted at symbol 100 of a codeword, followed by a full 255-symbol zero codeword -> exactly one synd_valid pulse, all syndromes 0, and no pulse for the aborted codeword.
- rst pulsed low for one cycle at symbol 50, then a new full codeword is sent, then two codewords back-to-back -> no pulse for the aborted codeword. The following codewords each produce one correct pulse, spaced N cycles apart.
